// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory port between the I-cache refill path and the D-cache
// refill/write-back path, with alternating priority and a sticky response timeout.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int CLSIZE         = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_strobe_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_done_o,
  output logic [CLSIZE-1:0] i_data_o,
  input  logic              d_strobe_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic              d_rw_i,
  input  logic [CLSIZE-1:0] d_data_i,
  output logic              d_done_o,
  output logic [CLSIZE-1:0] d_data_o,
  output logic              m_strobe_o,
  output logic [XLEN-1:0]   m_addr_o,
  output logic              m_rw_o,
  output logic [CLSIZE-1:0] m_data_o,
  input  logic              m_done_i,
  input  logic [CLSIZE-1:0] m_data_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_reg;
  logic            last_d_reg;   // 1 when the most recent grant went to the D side
  logic [CW-1:0]   cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      last_d_reg <= 1'b0;
      cnt_reg    <= '0;
      i_done_o   <= 1'b0;
      i_data_o   <= '0;
      d_done_o   <= 1'b0;
      d_data_o   <= '0;
      m_strobe_o <= 1'b0;
      m_addr_o   <= '0;
      m_rw_o     <= 1'b0;
      m_data_o   <= '0;
      grant_o    <= 2'b00;
      err_o      <= 1'b0;
    end else begin
      m_strobe_o <= 1'b0;
      i_done_o   <= 1'b0;
      d_done_o   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_strobe_i || d_strobe_i) begin
            // D wins when alone, or on a tie when I was served last
            if (d_strobe_i && (!i_strobe_i || !last_d_reg)) begin
              m_addr_o   <= d_addr_i;
              m_rw_o     <= d_rw_i;
              m_data_o   <= d_data_i;
              grant_o    <= 2'b10;
              last_d_reg <= 1'b1;
            end else begin
              m_addr_o   <= i_addr_i;
              m_rw_o     <= 1'b0;
              grant_o    <= 2'b01;
              last_d_reg <= 1'b0;
            end
            m_strobe_o <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT;
        WAIT: begin
          if (m_done_i) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            i_done_o  <= grant_o[0];
            d_done_o  <= grant_o[1];
            if (!m_rw_o) begin
              if (grant_o[1]) d_data_o <= m_data_i;
              else            i_data_o <= m_data_i;
            end
          end else begin
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
            // cnt_reg counts completed silent cycles, so this edge is the TIMEOUT_CYCLES-th
            if (TO_EN && cnt_reg >= CNT_LAST) err_o <= 1'b1;
          end
        end
        DONE: begin
          grant_o   <= 2'b00;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-timeline model of the arbiter kept in the bench.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int CLSIZE = 128;
  localparam int TO = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              i_strobe_i = 1'b0;
  logic [XLEN-1:0]   i_addr_i = '0;
  logic              i_done_o;
  logic [CLSIZE-1:0] i_data_o;
  logic              d_strobe_i = 1'b0;
  logic [XLEN-1:0]   d_addr_i = '0;
  logic              d_rw_i = 1'b0;
  logic [CLSIZE-1:0] d_data_i = '0;
  logic              d_done_o;
  logic [CLSIZE-1:0] d_data_o;
  logic              m_strobe_o;
  logic [XLEN-1:0]   m_addr_o;
  logic              m_rw_o;
  logic [CLSIZE-1:0] m_data_o;
  logic              m_done_i;
  logic [CLSIZE-1:0] m_data_i;
  logic [1:0]        grant_o;
  logic              err_o;

  mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_strobe_i(i_strobe_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_data_o(i_data_o),
    .d_strobe_i(d_strobe_i), .d_addr_i(d_addr_i), .d_rw_i(d_rw_i), .d_data_i(d_data_i),
    .d_done_o(d_done_o), .d_data_o(d_data_o),
    .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o), .m_data_o(m_data_o),
    .m_done_i(m_done_i), .m_data_i(m_data_i), .grant_o(grant_o), .err_o(err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- transaction-timeline reference model ----------------
  int          cyc = 0;
  bit          md_busy = 0, md_own_d = 0, md_resp = 0, md_last_d = 0;
  int          md_g = 0, md_r = 0;
  logic [1:0]  e_grant = '0;
  logic        e_mstb = 0, e_rw = 0, e_idone = 0, e_ddone = 0, e_err = 0;
  logic [31:0] e_addr = '0;
  logic [127:0] e_mdata = '0, e_idata = '0, e_ddata = '0;

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      md_busy = 0; md_resp = 0; md_last_d = 0;
      e_grant = '0; e_mstb = 0; e_rw = 0; e_idone = 0; e_ddone = 0; e_err = 0;
      e_addr = '0; e_mdata = '0; e_idata = '0; e_ddata = '0;
    end else begin
      cyc++;
      if (!md_busy) begin
        if (i_strobe_i || d_strobe_i) begin
          md_own_d  = (i_strobe_i && d_strobe_i) ? !md_last_d : d_strobe_i;
          md_last_d = md_own_d;
          md_busy   = 1;
          md_resp   = 0;
          md_g      = cyc;            // the cycle now starting carries the memory strobe
          e_addr    = md_own_d ? d_addr_i : i_addr_i;
          e_rw      = md_own_d ? d_rw_i : 1'b0;
          if (md_own_d) e_mdata = d_data_i;
          e_grant   = md_own_d ? 2'b10 : 2'b01;
        end
      end else if (!md_resp) begin
        if (cyc - 1 > md_g) begin     // a waiting cycle just ended
          if (m_done_i) begin
            md_resp = 1;
            md_r    = cyc - 1;
            if (!e_rw) begin
              if (md_own_d) e_ddata = m_data_i;
              else          e_idata = m_data_i;
            end
          end else if (TO != 0 && (cyc - 1 - md_g) >= TO) begin
            e_err = 1;
          end
        end
      end else if (cyc - 1 == md_r + 1) begin
        md_busy = 0;
        e_grant = 2'b00;
      end
      e_mstb  = md_busy && (cyc == md_g);
      e_idone = md_busy && md_resp && (cyc == md_r + 1) && !md_own_d;
      e_ddone = md_busy && md_resp && (cyc == md_r + 1) && md_own_d;
    end
  end

  // ---------------- per-cycle comparison and pulse counters ----------------
  int n_mstb = 0, n_idone = 0, n_ddone = 0;

  initial forever begin
    @(negedge clk_i);
    if (m_strobe_o) n_mstb++;
    if (i_done_o) n_idone++;
    if (d_done_o) n_ddone++;
    chk("grant_o", grant_o, e_grant);
    chk("m_strobe_o", m_strobe_o, e_mstb);
    chk("m_addr_o", m_addr_o, e_addr);
    chk("m_rw_o", m_rw_o, e_rw);
    chk("m_data_o", m_data_o, e_mdata);
    chk("i_done_o", i_done_o, e_idone);
    chk("d_done_o", d_done_o, e_ddone);
    chk("i_data_o", i_data_o, e_idata);
    chk("d_data_o", d_data_o, e_ddata);
    chk("err_o", err_o, e_err);
  end

  // ---------------- memory responder ----------------
  int          lat_fixed = -1;
  bit          mem_silent = 0, spur_en = 0, spur_force = 0, mem_fixed = 0;
  logic [127:0] mem_val = '0;
  bit          mem_busy = 0;
  int          mem_rem = 0;

  initial begin
    m_done_i = 1'b0;
    m_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mem_busy = 0;
        m_done_i = 1'b0;
      end else if (mem_busy) begin
        if (!mem_silent && mem_rem == 0) begin
          m_done_i = 1'b1;
          m_data_i = mem_fixed ? mem_val : rnd128();
          mem_busy = 0;
        end else begin
          if (mem_rem > 0) mem_rem--;
          m_done_i = 1'b0;
          m_data_i = rnd128();
        end
      end else begin
        m_done_i = spur_force ? 1'b1 : (spur_en ? ($urandom_range(0, 3) == 0) : 1'b0);
        m_data_i = rnd128();
        if (m_strobe_o) begin
          mem_busy = 1;
          mem_rem  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    do begin tick(); n++; end while (!m_strobe_o && n < 50);
    if (!m_strobe_o) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_wait: m_strobe_o not seen within 50 cycles, required 1");
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin tick(); n++; end while (!(i_done_o || d_done_o) && n < 50);
    if (!(i_done_o || d_done_o)) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: no done pulse within 50 cycles, required 1");
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant_o, 2'b00);
    chk({tag, "_mstb"}, m_strobe_o, 1'b0);
    chk({tag, "_maddr"}, m_addr_o, 32'h0);
    chk({tag, "_mrw"}, m_rw_o, 1'b0);
    chk({tag, "_mdata"}, m_data_o, 128'h0);
    chk({tag, "_idone"}, i_done_o, 1'b0);
    chk({tag, "_ddone"}, d_done_o, 1'b0);
    chk({tag, "_idata"}, i_data_o, 128'h0);
    chk({tag, "_ddata"}, d_data_o, 128'h0);
    chk({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  localparam logic [127:0] LINE1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LINE5 = 128'hFEDCBA9876543210FEDCBA9876543210;

  initial begin
    int n;
    int s_mstb, s_idone, s_ddone;
    logic [1:0] exp_g [5];
    logic [127:0] s_idata, s_ddata;
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    rst_i = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // single I read, memory answers two cycles after the strobe
    lat_fixed = 1; mem_fixed = 1; mem_val = LINE1;
    s_mstb = n_mstb; s_idone = n_idone; s_ddone = n_ddone;
    i_addr_i = 32'h8000_0040; i_strobe_i = 1'b1;
    wait_issue(n);
    chk("t1_issue_lat", n, 1);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_rw", m_rw_o, 1'b0);
    chk("t1_addr", m_addr_o, 32'h8000_0040);
    wait_done(n);
    chk("t1_done_lat", n, 3);
    chk("t1_idone", i_done_o, 1'b1);
    chk("t1_idata", i_data_o, LINE1);
    i_strobe_i = 1'b0;
    tick();
    chk("t1_mstb_count", n_mstb - s_mstb, 1);
    chk("t1_idone_count", n_idone - s_idone, 1);
    chk("t1_ddone_count", n_ddone - s_ddone, 0);

    // D write at minimum latency
    lat_fixed = 0;
    d_rw_i = 1'b1; d_addr_i = 32'h8000_1000; d_data_i = {4{32'hA5A5_A5A5}}; d_strobe_i = 1'b1;
    wait_issue(n);
    chk("t2_grant", grant_o, 2'b10);
    chk("t2_rw", m_rw_o, 1'b1);
    chk("t2_addr", m_addr_o, 32'h8000_1000);
    chk("t2_mdata", m_data_o, {4{32'hA5A5_A5A5}});
    wait_done(n);
    chk("t2_done_lat", n, 2);
    chk("t2_ddone", d_done_o, 1'b1);
    chk("t2_ddata_unchanged", d_data_o, 128'h0);
    chk("t2_idata_kept", i_data_o, LINE1);
    d_strobe_i = 1'b0; d_rw_i = 1'b0;
    repeat (2) tick();

    // spurious memory completions while idle
    s_mstb = n_mstb; s_idone = n_idone; s_ddone = n_ddone;
    s_idata = i_data_o; s_ddata = d_data_o;
    spur_force = 1;
    repeat (4) tick();
    spur_force = 0;
    tick();
    chk("t6_mstb_count", n_mstb - s_mstb, 0);
    chk("t6_idone_count", n_idone - s_idone, 0);
    chk("t6_ddone_count", n_ddone - s_ddone, 0);
    chk("t6_idata", i_data_o, s_idata);
    chk("t6_ddata", d_data_o, s_ddata);
    chk("t6_grant", grant_o, 2'b00);

    // simultaneous requests after reset: D, I, D, I, D with no extra idle cycles
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
    lat_fixed = 0; mem_fixed = 0;
    i_addr_i = 32'h0000_1100; d_addr_i = 32'h0000_2200; d_rw_i = 1'b0;
    i_strobe_i = 1'b1; d_strobe_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_issue(n);
      if (k == 1) chk("t3_gap", n, 2);
      chk($sformatf("t3_order%0d", k), grant_o, exp_g[k]);
      wait_done(n);
      if (d_done_o) begin
        if (k <= 2) d_addr_i = $urandom(); else d_strobe_i = 1'b0;
      end else begin
        if (k <= 2) i_addr_i = $urandom(); else i_strobe_i = 1'b0;
      end
    end
    tick();

    // silent memory: err_o sets after the 8th waiting cycle, late answer still completes
    lat_fixed = 0; mem_silent = 1;
    d_rw_i = 1'b0; d_addr_i = 32'h0000_3300; d_strobe_i = 1'b1;
    wait_issue(n);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) chk("t4_err_before", err_o, 1'b0);
      if (k == 9) chk("t4_err_after", err_o, 1'b1);
    end
    mem_silent = 0;
    wait_done(n);
    chk("t4_late_done_lat", n, 2);
    chk("t4_ddone", d_done_o, 1'b1);
    d_strobe_i = 1'b0;
    repeat (3) tick();
    chk("t4_err_sticky", err_o, 1'b1);

    // reset while waiting clears everything without a clock edge
    mem_silent = 1;
    i_addr_i = 32'h0000_4400; i_strobe_i = 1'b1;
    wait_issue(n);
    repeat (2) tick();
    #2 rst_i = 1'b1;
    #1 chk_all_zero("t5_async");
    i_strobe_i = 1'b0; mem_silent = 0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    lat_fixed = 2; mem_fixed = 1; mem_val = LINE5;
    d_rw_i = 1'b0; d_addr_i = 32'h0000_5500; d_strobe_i = 1'b1;
    wait_issue(n);
    chk("t5_grant", grant_o, 2'b10);
    wait_done(n);
    chk("t5_done_lat", n, 4);
    chk("t5_ddata", d_data_o, LINE5);
    d_strobe_i = 1'b0; mem_fixed = 0;
    tick();

    // randomized traffic with spurious completions, checked by the model every cycle
    lat_fixed = -1; spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (i_strobe_i && i_done_o) i_strobe_i = 1'b0;
      if (d_strobe_i && d_done_o) d_strobe_i = 1'b0;
      if (!i_strobe_i && $urandom_range(0, 3) == 0) begin
        i_addr_i = $urandom(); i_strobe_i = 1'b1;
      end
      if (!d_strobe_i && $urandom_range(0, 3) == 0) begin
        d_addr_i = $urandom(); d_rw_i = 1'($urandom_range(0, 1));
        d_data_i = rnd128(); d_strobe_i = 1'b1;
      end
    end
    i_strobe_i = 1'b0; d_strobe_i = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external cache-line memory port between the I-cache refill path and the D-cache refill/write-back path.
- Sits between the I/D caches (atomic unit on the D side) and the memory master interface.
- Serializes line transactions with alternating priority on simultaneous requests and routes returned lines to the owner.
- Flags a stalled memory response with a sticky timeout error.

Parameters:
XLEN, 32, address width in bits
CLSIZE, 128, cache-line width in bits
TIMEOUT_CYCLES, 4096, WAIT cycles before err_o sets; 0 disables the check

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
i_strobe_i  in  1  I-side request, level, held until i_done_o
i_addr_i  in  XLEN  I-side line address (read only)
i_done_o  out  1  one-cycle completion pulse to I side
i_data_o  out  CLSIZE  line returned to I side
d_strobe_i  in  1  D-side request, level, held until d_done_o
d_addr_i  in  XLEN  D-side line address
d_rw_i  in  1  D-side direction: 1 = write, 0 = read
d_data_i  in  CLSIZE  D-side write line
d_done_o  out  1  one-cycle completion pulse to D side
d_data_o  out  CLSIZE  line returned to D side
m_strobe_o  out  1  one-cycle request pulse to memory
m_addr_o  out  XLEN  memory address
m_rw_o  out  1  memory direction
m_data_o  out  CLSIZE  memory write line
m_done_i  in  1  memory completion
m_data_i  in  CLSIZE  memory read line
grant_o  out  2  one-hot owner {D,I}; 00 when idle
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state): FSM -> IDLE. All outputs 0, timeout counter 0, last_grant = I.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Only one strobe high: grant it.
  - Both high: grant the side opposite last_grant (after reset D wins first).
  - On grant: register m_addr_o from the granted address and set grant_o.
  - D grant: m_rw_o = d_rw_i, m_data_o = d_data_i.
  - I grant: m_rw_o = 0, m_data_o unchanged.
  - Update last_grant, go to ISSUE.
  - Neither strobe high: stay in IDLE, grant_o = 00.
- ISSUE: m_strobe_o = 1 for exactly this one cycle, then WAIT. Strobe never asserts in any other state.
- WAIT:
  - m_addr_o, m_rw_o, m_data_o hold. Timeout counter increments each cycle and saturates.
  - Counter reaches TIMEOUT_CYCLES (nonzero): err_o sets and stays set until reset. FSM keeps waiting; no abort.
  - m_done_i = 1: go to DONE and clear the counter.
    - Read for I: i_data_o <= m_data_i.
    - Read for D: d_data_o <= m_data_i.
    - Write: neither data output changes.
- DONE:
  - Owner's done output = 1 for this single cycle.
  - grant_o clears at the exit edge. Next state IDLE.
- Requester rule: each requester deasserts its strobe at the clock edge ending its done cycle, so IDLE never re-grants a completed request. A strobe still high in IDLE is a new request.
- m_done_i outside WAIT is ignored.
- Minimum occupancy per transaction: 3 cycles plus memory latency. Minimum strobe-to-done latency: 3 cycles with m_done_i in the first WAIT cycle.
- i_data_o and d_data_o hold their last value until overwritten by that side's next read completion.
- Strobes that rise or fall while another transaction is in flight are sampled only in IDLE. No request queueing beyond the level strobes.

Test Plan:
- Single I read: i_strobe_i=1 with addr 0x8000_0040, memory answers 2 cycles after m_strobe_o with 0x0123...CDEF. Expect m_strobe_o once, m_rw_o=0, grant_o=01, i_done_o pulse, i_data_o equals that line, d_done_o never high.
- D write: d_rw_i=1, addr 0x8000_1000, d_data_i=0xA5A5... Expect m_rw_o=1, m_data_o=0xA5A5..., d_done_o pulse, d_data_o unchanged.
- Simultaneous I and D strobes right after reset: D is served first and I second, with no idle gap beyond IDLE. Repeat with both held: grant order alternates D, I, D, I.
- TIMEOUT_CYCLES=8, memory silent: err_o rises after the 8th WAIT cycle. A late m_done_i still completes the transaction. err_o stays 1 until rst_i.
- rst_i asserted during WAIT: all outputs 0 immediately, without a clock edge. After release, a fresh D read completes normally with grant_o=10.
- Spurious m_done_i during IDLE: no done pulse, no data change, FSM stays in IDLE.
